la_event_sched: RTL and testbench

- Sequencer for the icestick logic analyzer, sitting between the synchronized probe pins and the UART transmitter.
- Detects changes on the pin bus and timestamps each change with the time since the previous recorded event.
- Queues events in a small FIFO and drives the UART byte-by-byte through a valid/ready handshake.
- Drops and flags events when the queue is full, so the serial link never stalls capture.

---
 rtl/la_event_sched.sv | 157 +++++++++++++++
 tb/tb_la_event_sched.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/la_event_sched.sv
// Logic-analyzer sequencer: timestamps pin-bus changes, queues them and
// serialises each event as a 3-byte frame over a valid/ready UART link.
module la_event_sched #(
  parameter int DEPTH    = 16,
  parameter int PRESCALE = 12
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] pin,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  input  logic       tx_ready,
  output logic       busy,
  output logic       overflow,
  output logic [1:0] state
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [12:0] DMAX = 13'h1FFF;

  typedef struct packed {
    logic [6:0]  pin;
    logic [12:0] delta;
    logic        ovf;
  } evt_t;

  typedef enum logic [1:0] {IDLE = 2'd0, S0 = 2'd1, S1 = 2'd2, S2 = 2'd3} state_t;

  // capture / timebase
  logic          armed;
  logic [6:0]    prev;
  logic [PW-1:0] presc;
  logic [12:0]   delta;

  // event queue
  evt_t          mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  evt_t          ev, head;

  // transmit side
  state_t        st, st_n;
  evt_t          hold, hold_n;
  logic [7:0]    tx_data_n;
  logic          tx_valid_n;

  logic change, pop, full, push, drop, tick, hs;

  assign change = armed && (pin != prev);
  assign pop    = (st == IDLE) && (count != '0);
  assign full   = (count == CW'(DEPTH));
  // a pop in the same cycle frees the slot the push needs
  assign push   = change && (!full || pop);
  assign drop   = change && full && !pop;
  assign tick   = (presc == PW'(PRESCALE - 1));
  assign hs     = tx_valid && tx_ready;

  assign ev    = '{pin: pin, delta: delta, ovf: overflow};
  assign head  = mem[rd_ptr];
  assign busy  = (count != '0) || (st != IDLE);
  assign state = st;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      armed    <= 1'b0;
      prev     <= '0;
      presc    <= '0;
      delta    <= '0;
      overflow <= 1'b0;
    end else if (!armed) begin
      armed <= 1'b1;
      prev  <= pin;
      presc <= '0;
      delta <= '0;
    end else begin
      if (change) prev <= pin;
      // a dropped event leaves the timebase running so the next stamp
      // still spans back to the last event that made it into the queue
      if (push) begin
        presc <= '0;
        delta <= '0;
      end else if (tick) begin
        presc <= '0;
        if (delta != DMAX) delta <= delta + 13'd1;
      end else begin
        presc <= presc + PW'(1);
      end
      if (push)      overflow <= 1'b0;
      else if (drop) overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= ev;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      st       <= IDLE;
      hold     <= '0;
      tx_valid <= 1'b0;
      tx_data  <= '0;
    end else begin
      st       <= st_n;
      hold     <= hold_n;
      tx_valid <= tx_valid_n;
      tx_data  <= tx_data_n;
    end
  end

  always_comb begin
    st_n       = st;
    hold_n     = hold;
    tx_valid_n = tx_valid;
    tx_data_n  = tx_data;
    case (st)
      IDLE: if (count != '0) begin
        hold_n     = head;
        tx_valid_n = 1'b1;
        tx_data_n  = {1'b1, head.pin};
        st_n       = S0;
      end
      S0: if (hs) begin
        tx_data_n = {1'b0, hold.ovf, hold.delta[12:7]};
        st_n      = S1;
      end
      S1: if (hs) begin
        tx_data_n = {1'b0, hold.delta[6:0]};
        st_n      = S2;
      end
      S2: if (hs) begin
        tx_valid_n = 1'b0;
        st_n       = IDLE;
      end
      default: st_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_la_event_sched.sv
// Directed bench for la_event_sched: frame contents, timestamps, saturation,
// overflow drop/flag, back-pressure and reset mid-frame.
module tb_la_event_sched;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [6:0] pin = 7'h08;
  logic       tx_ready = 1'b1;
  logic [7:0] tx_data;
  logic       tx_valid, busy, overflow;
  logic [1:0] state;

  int checks = 0;
  int errors = 0;
  logic [7:0] rxq[$];

  always #5 clk = ~clk;

  la_event_sched #(.DEPTH(16), .PRESCALE(3)) dut (
    .clk(clk), .reset(reset), .pin(pin),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .busy(busy), .overflow(overflow), .state(state)
  );

  // record every accepted byte (pre-edge values seen at the handshake edge)
  always @(posedge clk) if (tx_valid && tx_ready) rxq.push_back(tx_data);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_bytes(input string tag, input int n, input int budget);
    int t = 0;
    while (rxq.size() < n && t < budget) begin
      @(negedge clk);
      t++;
    end
    chk({tag, "_nbytes"}, rxq.size(), n);
  endtask

  task automatic chk_frame(input string tag, input logic [7:0] b0, input logic [7:0] b1,
                           input logic [7:0] b2);
    wait_bytes(tag, 3, 50);
    if (rxq.size() >= 3) begin
      chk({tag, "_b0"}, rxq[0], b0);
      chk({tag, "_b1"}, rxq[1], b1);
      chk({tag, "_b2"}, rxq[2], b2);
    end
    rxq.delete();
  endtask

  initial begin
    int t;
    logic [7:0] b;

    // reset values
    cyc(3);
    chk("rst_valid", tx_valid, 1'b0);
    chk("rst_data", tx_data, 8'h00);
    chk("rst_busy", busy, 1'b0);
    chk("rst_ovf", overflow, 1'b0);
    chk("rst_state", state, 2'd0);

    // 1: arm, then change 121 cycles later -> delta 40
    reset = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("arm_noevent", busy, 1'b0);
    repeat (121) @(posedge clk);
    @(negedge clk);
    pin = 7'h09;
    cyc(5);
    chk("t1_state", state, 2'd0);
    chk("t1_busy", busy, 1'b0);
    chk_frame("t1", 8'h89, 8'h00, 8'h28);

    // 2: 1 tick, then 130 ticks
    cyc(1);
    pin = 7'h0B;
    cyc(5);
    chk_frame("t2a", 8'h8B, 8'h00, 8'h01);
    cyc(387);
    pin = 7'h0A;
    cyc(5);
    chk_frame("t2b", 8'h8A, 8'h01, 8'h02);

    // 3: 10000 ticks saturates delta
    cyc(29996);
    pin = 7'h7F;
    cyc(5);
    chk_frame("t3", 8'hFF, 8'h3F, 8'h7F);
    chk("t3_state", state, 2'd0);
    chk("t3_busy", busy, 1'b0);

    // 4: stalled link, 18 back-to-back changes: 1 held, 16 queued, 1 dropped
    tx_ready = 1'b0;
    for (int i = 0; i < 18; i++) begin
      pin = 7'(i);
      cyc(1);
    end
    chk("t4_ovf", overflow, 1'b1);
    chk("t4_busy", busy, 1'b1);
    chk("t4_state", state, 2'd1);
    chk("t4_valid", tx_valid, 1'b1);
    chk("t4_hold_b0", tx_data, 8'h80);
    tx_ready = 1'b1;
    t = 0;
    while (busy && t < 300) begin
      cyc(1);
      t++;
    end
    chk("t4_drained", busy, 1'b0);
    chk("t4_nbytes", rxq.size(), 51);
    for (int j = 0; j < 17 && 3 * j + 1 < rxq.size(); j++) begin
      chk($sformatf("t4_f%0d_b0", j), rxq[3*j], 8'h80 | 8'(j));
      b = rxq[3*j+1];
      chk($sformatf("t4_f%0d_b1hi", j), b[7:6], 2'b00);
    end
    rxq.delete();
    chk("t4_ovf_sticky", overflow, 1'b1);
    pin = 7'h55;
    cyc(1);
    chk("t4_ovf_clr", overflow, 1'b0);
    cyc(9);
    wait_bytes("t4_post", 3, 50);
    if (rxq.size() >= 3) begin
      chk("t4_post_b0", rxq[0], 8'hD5);
      b = rxq[1];
      chk("t4_post_b1hi", b[7:6], 2'b01);
    end
    rxq.delete();

    // 5: back-pressure in S1, delta 133 -> B1=0x01, B2=0x05
    cyc(390);
    pin = 7'h22;
    cyc(3);
    tx_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      cyc(1);
      chk("t5_stall_data", tx_data, 8'h01);
      chk("t5_stall_valid", tx_valid, 1'b1);
      chk("t5_stall_state", state, 2'd2);
    end
    tx_ready = 1'b1;
    chk_frame("t5", 8'hA2, 8'h01, 8'h05);

    // 6: reset in S1, then re-arm and a fresh timestamp
    cyc(3);
    pin = 7'h33;
    cyc(3);
    chk("t6_in_s1", state, 2'd2);
    reset = 1'b1;
    #1;
    chk("t6_valid", tx_valid, 1'b0);
    chk("t6_state", state, 2'd0);
    chk("t6_busy", busy, 1'b0);
    chk("t6_data", tx_data, 8'h00);
    rxq.delete();
    cyc(2);
    reset = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("t6_arm_noevent", busy, 1'b0);
    repeat (11) @(posedge clk);
    @(negedge clk);
    pin = 7'h34;
    cyc(5);
    chk_frame("t6", 8'hB4, 8'h00, 8'h03);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
